// File: rtl/gte_microcode_sequencer_pkg.sv
// gte_seq_pkg: shared state encoding, COP2 command field positions and
// constants for the GTE microcode sequencer.
package gte_seq_pkg;

  // Default widths of the program counter and the cycle counter.
  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 6;

  // COP2 command word width and field bit positions.
  localparam int CMD_W   = 25;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 5;
  localparam int LM_BIT  = 10;
  localparam int CV_LSB  = 13;
  localparam int CV_MSB  = 14;
  localparam int VX_LSB  = 15;
  localparam int VX_MSB  = 16;
  localparam int MX_LSB  = 17;
  localparam int MX_MSB  = 18;
  localparam int SF_BIT  = 19;

  // MVMVA with cv=2 selects the hardware-bug microcode variant.
  localparam logic [5:0] OPC_MVMVA = 6'h12;
  localparam logic [1:0] CV_BUGGY  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_PAD  = 2'd2
  } seq_state_e;

  // Command fields held for the datapath while a command runs.
  typedef struct packed {
    logic       sf;
    logic       lm;
    logic [1:0] mx;
    logic [1:0] vx;
    logic [1:0] cv;
  } cmd_fields_t;

  // True when the command selects the buggy MVMVA microcode slot.
  function automatic logic is_buggy_mvmva(input logic [5:0] opcode,
                                          input logic [1:0] cv);
    return (opcode == OPC_MVMVA) && (cv == CV_BUGGY);
  endfunction

endpackage

// File: rtl/gte_microcode_sequencer_if.sv
// gte_microcode_sequencer_if: COP2 command port plus microcode ROM and
// datapath control signals of the sequencer. The master side is the CPU/ROM
// environment, the slave side is the sequencer itself.
interface gte_microcode_sequencer_if #(
  parameter int PC_W = 8
);
  import gte_seq_pkg::*;

  logic              i_run;
  logic [CMD_W-1:0]  i_cmd;
  logic              i_stall;
  logic              i_ucLast;
  logic [PC_W-1:0]   o_pc;
  logic              o_ucValid;
  logic              o_sf;
  logic              o_lm;
  logic [1:0]        o_mx;
  logic [1:0]        o_vx;
  logic [1:0]        o_cv;
  logic              o_busy;
  logic              o_done;
  logic              o_overrun;
  logic              o_error;

  modport master (
    output i_run, i_cmd, i_stall, i_ucLast,
    input  o_pc, o_ucValid, o_sf, o_lm, o_mx, o_vx, o_cv,
           o_busy, o_done, o_overrun, o_error
  );

  modport slave (
    input  i_run, i_cmd, i_stall, i_ucLast,
    output o_pc, o_ucValid, o_sf, o_lm, o_mx, o_vx, o_cv,
           o_busy, o_done, o_overrun, o_error
  );

endinterface

// File: rtl/gte_microcode_sequencer_start.sv
// gte_microcode_sequencer_start: maps a GTE opcode to its microcode start
// address and official PS1 cycle count. Unassigned opcodes are NOP slots
// that share the program at 8'hFE and have an official count of 0.
module gte_microcode_sequencer_start
  import gte_seq_pkg::*;
(
  input  logic       isBuggyMVMVA,
  input  logic [5:0] Instruction,
  output logic [7:0] StartAddress,
  output logic [5:0] officialCycleCount
);

  // Opcode lookup table; buggy MVMVA runs from its own slot.
  always_comb begin
    StartAddress       = 8'hFE;
    officialCycleCount = 6'd0;
    case (Instruction)
      6'h01:     begin StartAddress = 8'h00; officialCycleCount = 6'd15; end // RTPS
      6'h06:     begin StartAddress = 8'h10; officialCycleCount = 6'd8;  end // NCLIP
      6'h0C:     begin StartAddress = 8'h18; officialCycleCount = 6'd6;  end // OP
      6'h10:     begin StartAddress = 8'h20; officialCycleCount = 6'd8;  end // DPCS
      6'h11:     begin StartAddress = 8'h28; officialCycleCount = 6'd8;  end // INTPL
      OPC_MVMVA: begin
        if (isBuggyMVMVA) begin
          StartAddress = 8'h38;
        end else begin
          StartAddress = 8'h30;
        end
        officialCycleCount = 6'd8;
      end
      6'h13:     begin StartAddress = 8'h40; officialCycleCount = 6'd19; end // NCDS
      6'h14:     begin StartAddress = 8'h50; officialCycleCount = 6'd13; end // CDP
      6'h16:     begin StartAddress = 8'h60; officialCycleCount = 6'd44; end // NCDT
      6'h1B:     begin StartAddress = 8'h80; officialCycleCount = 6'd17; end // NCCS
      6'h1C:     begin StartAddress = 8'h90; officialCycleCount = 6'd11; end // CC
      6'h1E:     begin StartAddress = 8'h98; officialCycleCount = 6'd14; end // NCS
      6'h20:     begin StartAddress = 8'hA0; officialCycleCount = 6'd30; end // NCT
      6'h28:     begin StartAddress = 8'hB8; officialCycleCount = 6'd5;  end // SQR
      6'h29:     begin StartAddress = 8'hC0; officialCycleCount = 6'd8;  end // DCPL
      6'h2A:     begin StartAddress = 8'hC8; officialCycleCount = 6'd17; end // DPCT
      6'h2D:     begin StartAddress = 8'hD8; officialCycleCount = 6'd5;  end // AVSZ3
      6'h2E:     begin StartAddress = 8'hE0; officialCycleCount = 6'd6;  end // AVSZ4
      6'h30:     begin StartAddress = 8'hE8; officialCycleCount = 6'd23; end // RTPT
      6'h3D:     begin StartAddress = 8'hF0; officialCycleCount = 6'd5;  end // GPF
      6'h3E:     begin StartAddress = 8'hF4; officialCycleCount = 6'd5;  end // GPL
      6'h3F:     begin StartAddress = 8'h70; officialCycleCount = 6'd39; end // NCCT
      default:   begin StartAddress = 8'hFE; officialCycleCount = 6'd0;  end // NOP slot
    endcase
  end

endmodule

// File: rtl/gte_microcode_sequencer.sv
// gte_microcode_sequencer: accepts one COP2 command, looks up its microcode
// start address and official cycle count, then steps the program counter
// through the external microcode ROM until the end-of-program bit.
// Build option PAD_CYCLES_EN: when defined, busy time is padded up to the
// official PS1 cycle count through an extra PAD state.
module gte_microcode_sequencer
  import gte_seq_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                      i_clk,
  input logic                      i_rst,
  gte_microcode_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e       state_q,   state_d;
  logic [PC_W-1:0]  pc_q,      pc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  cmd_fields_t      fields_q,  fields_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             overrun_q, overrun_d;
  logic             error_q,   error_d;
`ifdef PAD_CYCLES_EN
  logic [CNT_W-1:0] cnt_target_q, cnt_target_d;
`endif

  logic [5:0]       opcode_s;
  cmd_fields_t      fields_in_s;
  logic             buggy_s;
  logic [7:0]       start_addr_s;
  logic [5:0]       official_cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             unused_s;

  // Command decode straight from the issue port.
  assign opcode_s    = bus.i_cmd[OPC_MSB:OPC_LSB];
  assign fields_in_s = {bus.i_cmd[SF_BIT], bus.i_cmd[LM_BIT],
                        bus.i_cmd[MX_MSB:MX_LSB], bus.i_cmd[VX_MSB:VX_LSB],
                        bus.i_cmd[CV_MSB:CV_LSB]};
  assign buggy_s     = is_buggy_mvmva(opcode_s, fields_in_s.cv);

  // Cycle counter sticks at all-ones instead of wrapping.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  gte_microcode_sequencer_start u_start (
    .isBuggyMVMVA       (buggy_s),
    .Instruction        (opcode_s),
    .StartAddress       (start_addr_s),
    .officialCycleCount (official_cnt_s)
  );

  // Command word bits with no meaning to the sequencer.
`ifdef PAD_CYCLES_EN
  assign unused_s = ^{bus.i_cmd[24:20], bus.i_cmd[12:11], bus.i_cmd[9:6]};
`else
  assign unused_s = ^{bus.i_cmd[24:20], bus.i_cmd[12:11], bus.i_cmd[9:6],
                      official_cnt_s};
`endif

  // Next-state, program counter, counter and pulse computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    fields_d  = fields_q;
    error_d   = error_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
`ifdef PAD_CYCLES_EN
    cnt_target_d = cnt_target_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_run) begin
          fields_d = fields_in_s;
          pc_d     = PC_W'(start_addr_s);
          cnt_d    = CNT_ONE;
          error_d  = 1'b0;
          state_d  = ST_EXEC;
`ifdef PAD_CYCLES_EN
          cnt_target_d = CNT_W'(official_cnt_s);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        overrun_d = bus.i_run;
        if (!bus.i_stall) begin
          cnt_d = cnt_inc_s;
          if (bus.i_ucLast) begin
`ifdef PAD_CYCLES_EN
            // A zero official count never exceeds cnt, so NOP slots skip PAD.
            if (cnt_q < cnt_target_q) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else if (pc_q == PC_MAX) begin
            // Runaway program: abort rather than wrap the PC.
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_PAD: begin
`ifdef PAD_CYCLES_EN
        overrun_d = bus.i_run;
        if (!bus.i_stall) begin
          cnt_d = cnt_inc_s;
          if (cnt_q == cnt_target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PAD;
          end
        end else begin
          state_d = ST_PAD;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= {PC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      fields_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      error_q   <= 1'b0;
`ifdef PAD_CYCLES_EN
      cnt_target_q <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      fields_q  <= fields_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      error_q   <= error_d;
`ifdef PAD_CYCLES_EN
      cnt_target_q <= cnt_target_d;
`endif
    end
  end

  assign bus.o_pc      = pc_q;
  assign bus.o_ucValid = (state_q == ST_EXEC) && !bus.i_stall;
  assign bus.o_sf      = fields_q.sf;
  assign bus.o_lm      = fields_q.lm;
  assign bus.o_mx      = fields_q.mx;
  assign bus.o_vx      = fields_q.vx;
  assign bus.o_cv      = fields_q.cv;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_overrun = overrun_q;
  assign bus.o_error   = error_q;

endmodule

// File: tb/tb_gte_microcode_sequencer.sv
// tb_gte_microcode_sequencer: directed scenarios for the GTE microcode
// sequencer with a one-line ROM model (end-of-program at a chosen address).
module tb_gte_microcode_sequencer;

`ifdef PAD_CYCLES_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] rom_last;
  logic       rom_en;
  logic [7:0] pc_log[$];
  logic [7:0] stall_pc_log[$];

  gte_microcode_sequencer_if #(.PC_W(8)) bus ();

  gte_microcode_sequencer #(.PC_W(8), .CNT_W(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ROM model: the word at rom_last carries the end-of-program bit.
  assign bus.i_ucLast = rom_en && (bus.o_pc == rom_last);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk_cmd(input logic [5:0] op, input logic sf,
                                         input logic [1:0] mx, input logic [1:0] vx,
                                         input logic [1:0] cv, input logic lm);
    logic [24:0] c;
    c        = 25'd0;
    c[5:0]   = op;
    c[10]    = lm;
    c[14:13] = cv;
    c[16:15] = vx;
    c[18:17] = mx;
    c[19]    = sf;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [24:0] cmd);
    bus.i_cmd = cmd;
    bus.i_run = 1'b1;
    tick();
    bus.i_run = 1'b0;
  endtask

  // Runs the current command to o_done; returns busy and overrun counts.
  task automatic run_cmd(input int stall_from, input int stall_len, input int run_at,
                         input logic [24:0] run_word,
                         output int busy_n, output int ov_n, output bit timed_out);
    busy_n = 0;
    ov_n = 0;
    timed_out = 1'b1;
    pc_log.delete();
    stall_pc_log.delete();
    for (int c = 0; c < 200; c++) begin
      bus.i_stall = (c >= stall_from) && (c < stall_from + stall_len);
      bus.i_run   = (c == run_at);
      if (c == run_at) bus.i_cmd = run_word;
      #1;
      if (bus.o_overrun) ov_n++;
      if (bus.o_done) begin
        timed_out = 1'b0;
        break;
      end
      if (bus.o_busy) busy_n++;
      if (bus.o_ucValid) pc_log.push_back(bus.o_pc);
      if (bus.i_stall) stall_pc_log.push_back(bus.o_pc);
      tick();
    end
    bus.i_stall = 1'b0;
    bus.i_run   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.o_pc, bus.o_busy, bus.o_ucValid, bus.o_done, bus.o_overrun, bus.o_error} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got pc=%h busy=%b valid=%b done=%b ov=%b err=%b expected all 0",
               bus.o_pc, bus.o_busy, bus.o_ucValid, bus.o_done, bus.o_overrun, bus.o_error);
    end
    checks++;
    if ({bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv} !== 8'h00) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 00", {bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rtps_padding();
    int busy_n, ov_n;
    bit to, seq_ok;
    rom_en = 1'b1;
    rom_last = 8'h09;
    issue(mk_cmd(6'h01, 1'b1, 2'd1, 2'd3, 2'd0, 1'b1));
    run_cmd(-1, 0, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to) begin errors++; $display("FAIL rtps_timeout: no o_done within 200 cycles"); end
    checks++;
    if (busy_n !== (PAD ? 15 : 10)) begin
      errors++; $display("FAIL rtps_busy: got %0d expected %0d", busy_n, PAD ? 15 : 10);
    end
    seq_ok = (pc_log.size() == 10);
    for (int i = 0; i < pc_log.size(); i++) if (pc_log[i] !== 8'(i)) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++; $display("FAIL rtps_pc_seq: got %0d valid words first=%h expected 10 words 00..09",
                         pc_log.size(), (pc_log.size() > 0) ? pc_log[0] : 8'h00);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rtps_done_busy: got %b expected 0", bus.o_busy); end
    checks++;
    if ({bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv} !== 8'hDC) begin
      errors++; $display("FAIL rtps_fields: got %h expected dc", {bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv});
    end
    tick();
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL rtps_done_pulse: got %b expected 0", bus.o_done); end
  endtask

  task automatic test_mvmva(input logic [1:0] cv, input logic exp_buggy, input logic [7:0] exp_start);
    int busy_n, ov_n;
    bit to;
    rom_last = exp_start + 8'd2;
    bus.i_cmd = mk_cmd(6'h12, 1'b0, 2'd0, 2'd0, cv, 1'b0);
    bus.i_run = 1'b1;
    #1;
    checks++;
    if (dut.u_start.isBuggyMVMVA !== exp_buggy || dut.u_start.StartAddress !== exp_start) begin
      errors++; $display("FAIL mvmva_lookup: got buggy=%b start=%h expected buggy=%b start=%h",
                         dut.u_start.isBuggyMVMVA, dut.u_start.StartAddress, exp_buggy, exp_start);
    end
    tick();
    bus.i_run = 1'b0;
    run_cmd(-1, 0, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to || pc_log.size() == 0 || pc_log[0] !== exp_start) begin
      errors++; $display("FAIL mvmva_start_pc: got %h expected %h",
                         (pc_log.size() > 0) ? pc_log[0] : 8'h00, exp_start);
    end
    checks++;
    if (busy_n !== (PAD ? 8 : 3) || bus.o_cv !== cv) begin
      errors++; $display("FAIL mvmva_busy_cv: got busy=%0d cv=%0d expected busy=%0d cv=%0d",
                         busy_n, bus.o_cv, PAD ? 8 : 3, cv);
    end
  endtask

  task automatic test_stall();
    int busy_n, ov_n;
    bit to, ok;
    rom_last = 8'h13;
    issue(mk_cmd(6'h06, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    run_cmd(1, 3, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to || busy_n !== (PAD ? 11 : 7)) begin
      errors++; $display("FAIL stall_busy: got %0d (timeout=%b) expected %0d", busy_n, to, PAD ? 11 : 7);
    end
    ok = (pc_log.size() == 4);
    for (int i = 0; i < pc_log.size(); i++) if (pc_log[i] !== 8'h10 + 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_pc_seq: got %0d valid words expected 10..13", pc_log.size()); end
    ok = (stall_pc_log.size() == 3);
    for (int i = 0; i < stall_pc_log.size(); i++) if (stall_pc_log[i] !== 8'h11) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_pc_hold: got %0d held samples expected 3 at pc 11", stall_pc_log.size()); end
    tick();
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL stall_done_once: got %b expected 0", bus.o_done); end
  endtask

  task automatic test_overrun_back_to_back();
    int busy_n, ov_n;
    bit to;
    rom_last = 8'h13;
    issue(mk_cmd(6'h06, 1'b0, 2'd2, 2'd1, 2'd1, 1'b0));
    run_cmd(-1, 0, 2, mk_cmd(6'h30, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1), busy_n, ov_n, to);
    checks++;
    if (to || ov_n !== 1 || busy_n !== (PAD ? 8 : 4)) begin
      errors++; $display("FAIL overrun_pulse: got ov=%0d busy=%0d expected ov=1 busy=%0d", ov_n, busy_n, PAD ? 8 : 4);
    end
    checks++;
    if ({bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv} !== 8'h25) begin
      errors++; $display("FAIL overrun_fields: got %h expected 25", {bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv});
    end
    // New command issued in the o_done cycle.
    rom_last = 8'h19;
    issue(mk_cmd(6'h0C, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0));
    run_cmd(-1, 0, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to || pc_log.size() == 0 || pc_log[0] !== 8'h18 || busy_n !== (PAD ? 6 : 2) || ov_n !== 0) begin
      errors++; $display("FAIL b2b_accept: got pc0=%h busy=%0d ov=%0d expected pc0=18 busy=%0d ov=0",
                         (pc_log.size() > 0) ? pc_log[0] : 8'h00, busy_n, ov_n, PAD ? 6 : 2);
    end
    checks++;
    if ({bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv} !== 8'h80) begin
      errors++; $display("FAIL b2b_fields: got %h expected 80", {bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv});
    end
  endtask

  task automatic test_zero_count();
    int busy_n, ov_n;
    bit to;
    rom_last = 8'hFE;
    issue(mk_cmd(6'h02, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    run_cmd(-1, 0, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to || busy_n !== 1 || pc_log.size() != 1 || bus.o_error !== 1'b0) begin
      errors++; $display("FAIL zero_count: got busy=%0d words=%0d err=%b expected busy=1 words=1 err=0",
                         busy_n, pc_log.size(), bus.o_error);
    end
  endtask

  task automatic test_wrap();
    int busy_n, ov_n;
    bit to;
    rom_en = 1'b0;
    issue(mk_cmd(6'h00, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0));
    run_cmd(-1, 0, -1, 25'd0, busy_n, ov_n, to);
    checks++;
    if (to || busy_n !== 2 || pc_log.size() != 2 || pc_log[0] !== 8'hFE || pc_log[1] !== 8'hFF) begin
      errors++; $display("FAIL wrap_seq: got busy=%0d words=%0d expected busy=2 words FE,FF", busy_n, pc_log.size());
    end
    checks++;
    if (bus.o_error !== 1'b1) begin errors++; $display("FAIL wrap_error: got %b expected 1", bus.o_error); end
    tick();
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL wrap_sticky: got err=%b done=%b expected err=1 done=0", bus.o_error, bus.o_done);
    end
    rom_en = 1'b1;
  endtask

  task automatic test_reset_mid_exec();
    bit done_seen;
    rom_last = 8'h13;
    issue(mk_cmd(6'h06, 1'b1, 2'd3, 2'd3, 2'd3, 1'b1));
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL err_clear: got err=%b busy=%b expected err=0 busy=1", bus.o_error, bus.o_busy);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.o_pc, bus.o_busy, bus.o_ucValid, bus.o_done, bus.o_overrun, bus.o_error} !== 13'd0) begin
      errors++; $display("FAIL midreset_ctrl: got pc=%h busy=%b valid=%b done=%b ov=%b err=%b expected all 0",
                         bus.o_pc, bus.o_busy, bus.o_ucValid, bus.o_done, bus.o_overrun, bus.o_error);
    end
    checks++;
    if ({bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv} !== 8'h00) begin
      errors++; $display("FAIL midreset_fields: got %h expected 00", {bus.o_sf, bus.o_lm, bus.o_mx, bus.o_vx, bus.o_cv});
    end
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_done || bus.o_busy) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL midreset_no_done: got activity after reset expected none"); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rom_en = 1'b1;
    rom_last = 8'h00;
    bus.i_run = 1'b0;
    bus.i_cmd = 25'd0;
    bus.i_stall = 1'b0;
    test_reset();
    test_rtps_padding();
    test_mvmva(2'd2, 1'b1, 8'h38);
    test_mvmva(2'd0, 1'b0, 8'h30);
    test_stall();
    test_overrun_back_to_back();
    test_zero_count();
    test_wrap();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gte_microcode_sequencer.md
# gte_microcode_sequencer

Sequences one GTE command from issue to completion. Decodes the COP2 command word, obtains the microcode start address and official cycle count from the start-address lookup, then steps a program counter through the microcode ROM until the end-of-program flag. Optionally pads busy time to the official PS1 cycle count. Sits between the CPU COP2 command port and the GTE microcode ROM and datapath.

## Interface
Parameters:
- `PC_W`, default 8: width of the microcode program counter.
- `CNT_W`, default 6: width of the cycle counter and of the official cycle count.

Ports. One clock; reset is synchronous and active-high.
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_run`, in, 1: command issue strobe, sampled with `i_cmd`.
- `i_cmd`, in, 25: COP2 command word.
  - [5:0] opcode
  - [10] lm
  - [14:13] cv
  - [16:15] vx
  - [18:17] mx
  - [19] sf
- `i_stall`, in, 1: freezes sequencing for this cycle.
- `i_ucLast`, in, 1: end-of-program bit of the ROM word at `o_pc`. Combinational from the ROM.
- `o_pc`, out, PC_W: microcode ROM address.
- `o_ucValid`, out, 1: the word at `o_pc` executes this cycle. Equals EXEC state and not `i_stall`.
- `o_sf`, `o_lm`, out, 1 each: latched command fields.
- `o_mx`, `o_vx`, `o_cv`, out, 2 each: latched command fields.
- `o_busy`, out, 1: a command is in progress.
- `o_done`, out, 1: one-cycle pulse when the command completes.
- `o_overrun`, out, 1: one-cycle pulse when `i_run` arrives while busy.
- `o_error`, out, 1: sticky flag for PC wrap. Cleared by the next accepted `i_run` or by reset.

## Operation
States are IDLE, EXEC and PAD.

- **IDLE**
  - On `i_run`: latch the command fields and `buggy = (opcode==6'h12 && cv==2'd2)`.
  - Drive the lookup with the opcode and `buggy`. Latch the start address into `o_pc` and the official count into `cntTarget`.
  - Set `cnt=1`, clear `o_error`, go to EXEC.
- **EXEC**
  - Each cycle without stall: `o_pc` increments.
  - If `i_ucLast`: go to PAD when `PAD_CYCLES_EN` is defined and `cnt < cntTarget`; otherwise go to IDLE and pulse `o_done`.
  - `cnt` increments each non-stalled cycle and saturates at all-ones.
- **PAD**
  - `o_ucValid=0`. `cnt` increments each non-stalled cycle.
  - When `cnt == cntTarget` and not stalled: go to IDLE and pulse `o_done`.
- **Stall**: `i_stall` freezes the state, `o_pc` and `cnt` in EXEC and PAD. It has no effect in IDLE.
- **Wrap**: if `o_pc` is all-ones and the word is not last, set `o_error`, pulse `o_done` and go to IDLE. The PC never wraps.
- **Overrun**: `i_run` in EXEC or PAD is ignored and `o_overrun` pulses. Latched fields stay unchanged.
- **Zero count**: an official count of 0 (NOP slots) means no padding.
- **Reset**: reset at any time, including mid-command, forces the reset values below. Any in-flight command is discarded with no `o_done`.

Reset values of all outputs:
- IDLE state.
- `o_pc=0`.
- `o_busy`, `o_ucValid`, `o_done`, `o_overrun`, `o_error` all 0.
- All latched fields 0.

## Timing
- `i_run` in cycle N (IDLE) gives, in cycle N+1:
  - `o_busy=1`, `o_ucValid=1`, `o_pc` equal to the start address;
  - latched fields valid.
- Lookup path: combinational from `i_cmd` to the registers. `o_busy` is registered.
- Busy duration with no stall:
  - with padding, `max(L, C)` cycles, where L = microcode words executed and C = official count;
  - without padding, L cycles.
- Each stalled cycle adds one cycle.
- `o_done` is high in the first cycle with `o_busy=0`. A new `i_run` is accepted in that same cycle.
- Back-to-back throughput: one command per (busy + 1) cycles.

## Configuration
- `PAD_CYCLES_EN` defined: PAD state is present and busy lasts at least the official count (cycle-accurate PS1 timing).
- `PAD_CYCLES_EN` undefined: PAD state and `cntTarget` compare are removed and busy drops after the last microcode word. The cycle counter remains for debug.

## Structure
- Package `gte_seq_pkg`:
  - state enum;
  - command field bit positions;
  - `OPC_MVMVA=6'h12` and `CV_BUGGY=2'd2`;
  - `PC_W` and `CNT_W` defaults.
- One sub-module: `u_start`, an instance of the start-address and official-count lookup. It takes `isBuggyMVMVA` and `Instruction[5:0]` and returns `StartAddress[7:0]` and `officialCycleCount[5:0]`.
- The ROM is external.

## Test plan
- **RTPS, long program, padding**: opcode 6'h01, bench ROM program of 10 words from lookup address, official count 15, padding on. Expect `o_ucValid` for 10 cycles with `o_pc` incrementing, then 5 PAD cycles, `o_busy` high 15 cycles, then one `o_done` pulse.
- **Padding off**: same command without `PAD_CYCLES_EN`. Expect busy for 10 cycles.
- **Buggy MVMVA**: opcode 6'h12 with cv=2 gives `isBuggyMVMVA=1` at the lookup and the buggy-slot start address. With cv=0, expect the normal MVMVA start address and `o_cv` latched as 0.
- **Stall**: 3-cycle `i_stall` in the middle of NCLIP (opcode 6'h06, count 8, 4-word program). Expect `o_pc` held during the stall, busy extended to 11 cycles, `o_done` once.
- **Overrun**: `i_run` with opcode 6'h30 during busy. Expect one `o_overrun` pulse, latched fields unchanged, normal completion. A second `i_run` in the `o_done` cycle is accepted.
- **Wrap and reset**:
  - Start at 8'hFE with `i_ucLast` never asserted: expect `o_error=1` and `o_done` after `o_pc=8'hFF`.
  - Assert `i_rst` mid-EXEC: expect all outputs 0 in the next cycle and no `o_done`.
